// File: rtl/encoder_pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : encoder_pwm_gen                                               |
// | Purpose  : Constant-period PWM frame generator whose high time encodes a |
// |            position value (encoder emulator / reader loopback source).   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module encoder_pwm_gen #(
  parameter int P_DWIDTH     = 12,
  parameter int P_PRESCALE   = 4,
  parameter int P_INIT_TICKS = 16,
  parameter int P_EXIT_TICKS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [P_DWIDTH-1:0] i_pos,
  input  logic                i_pos_wr,
  output logic                o_pwm,
  output logic                o_frame_start,
  output logic                o_busy,
  output logic [P_DWIDTH-1:0] o_pos_active
);

  localparam int c_FRAME = P_INIT_TICKS + (1 << P_DWIDTH) + P_EXIT_TICKS;
  localparam int c_TW    = $clog2(c_FRAME) + 1;
  localparam int c_PW    = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;

  localparam logic [c_TW-1:0] c_FRAME_T = c_TW'(c_FRAME);
  localparam logic [c_TW-1:0] c_INIT_T  = c_TW'(P_INIT_TICKS);
  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(P_PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;
  logic                w_tick;
  logic [c_TW-1:0]     w_tick_inc;
  logic [c_TW-1:0]     w_high_ticks;

  logic [c_PW-1:0]     r_pre;
  logic [c_TW-1:0]     r_tick;
  logic [P_DWIDTH-1:0] r_pending;
  logic [P_DWIDTH-1:0] r_pos_active;
  logic                r_pwm;
  logic                r_frame_start;
  logic                r_busy;

  // r_tick counts ticks from frame start across both phases, so the frame
  // period stays fixed regardless of the encoded position.
  assign w_tick       = (r_pre == c_PRE_MAX);
  assign w_tick_inc   = r_tick + c_TW'(1);
  assign w_high_ticks = c_INIT_T + c_TW'(r_pos_active);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_state_nxt = S_HIGH;
          w_start     = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_tick && (w_tick_inc == w_high_ticks)) begin
          w_state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (w_tick && (w_tick_inc == c_FRAME_T)) begin
          if (i_en) begin
            w_state_nxt = S_HIGH;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so o_pwm can never glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre         <= '0;
      r_tick        <= '0;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pwm         <= (w_state_nxt == S_HIGH);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_frame_start <= w_start;
      if (w_start || (w_state_nxt == S_IDLE)) begin
        r_pre  <= '0;
        r_tick <= '0;
      end else if (w_tick) begin
        r_pre  <= '0;
        r_tick <= w_tick_inc;
      end else begin
        r_pre  <= r_pre + c_PW'(1);
      end
    end
  end

  // A write landing on the load cycle itself takes priority over pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending    <= '0;
      r_pos_active <= '0;
    end else begin
      if (i_pos_wr) begin
        r_pending <= i_pos;
      end
      if (w_start) begin
        r_pos_active <= i_pos_wr ? i_pos : r_pending;
      end
    end
  end

  assign o_pwm         = r_pwm;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;
  assign o_pos_active  = r_pos_active;

endmodule
`default_nettype wire

// File: tb/tb_encoder_pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_encoder_pwm_gen                                            |
// | Purpose  : Self-checking bench for encoder_pwm_gen (three instances).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_encoder_pwm_gen;

  // Small instance C parameters: frame = (3 + 16 + 2) ticks * 2 clocks = 42
  localparam int C_PRE   = 2;
  localparam int C_INIT  = 3;
  localparam int C_FRAME_CLK = (3 + 16 + 2) * 2;

  logic clk = 1'b0;
  logic rst_n;

  logic        en_a, wr_a, pwm_a, fs_a, busy_a;
  logic [11:0] pos_a, act_a;
  logic        en_b, wr_b, pwm_b, fs_b, busy_b;
  logic [11:0] pos_b, act_b;
  logic        en_c, wr_c, pwm_c, fs_c, busy_c;
  logic [3:0]  pos_c, act_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_pwm_gen #(.P_DWIDTH(12), .P_PRESCALE(1), .P_INIT_TICKS(16), .P_EXIT_TICKS(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_pos(pos_a), .i_pos_wr(wr_a),
    .o_pwm(pwm_a), .o_frame_start(fs_a), .o_busy(busy_a), .o_pos_active(act_a));

  encoder_pwm_gen u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_pos(pos_b), .i_pos_wr(wr_b),
    .o_pwm(pwm_b), .o_frame_start(fs_b), .o_busy(busy_b), .o_pos_active(act_b));

  encoder_pwm_gen #(.P_DWIDTH(4), .P_PRESCALE(C_PRE), .P_INIT_TICKS(C_INIT), .P_EXIT_TICKS(2)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_c), .i_pos(pos_c), .i_pos_wr(wr_c),
    .o_pwm(pwm_c), .o_frame_start(fs_c), .o_busy(busy_c), .o_pos_active(act_c));

  typedef struct {
    int pend;
    int pos;
    bit load_wr;
    int exp_act;
    int exp_hi;
    int exp_lo;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_pwm(input int s);
    case (s)
      0:       return pwm_a;
      1:       return pwm_b;
      default: return pwm_c;
    endcase
  endfunction

  function automatic logic get_fs(input int s);
    case (s)
      0:       return fs_a;
      1:       return fs_b;
      default: return fs_c;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_en(input int s);
    case (s)
      0:       return en_a;
      1:       return en_b;
      default: return en_c;
    endcase
  endfunction

  task automatic set_in(input int s, input logic en, input logic wr, input int pos);
    case (s)
      0:       begin en_a = en; wr_a = wr; pos_a = 12'(pos); end
      1:       begin en_b = en; wr_b = wr; pos_b = 12'(pos); end
      default: begin en_c = en; wr_c = wr; pos_c = 4'(pos); end
    endcase
  endtask

  task automatic drive_step(input int s, input int cyc, input int drop_at,
                            input int w1_at, input int w1_val, input int w2_at, input int w2_val,
                            inout logic en_keep);
    logic wv;
    int   pv;
    if (cyc == drop_at) en_keep = 1'b0;
    wv = (cyc == w1_at) || (cyc == w2_at);
    pv = (cyc == w2_at) ? w2_val : w1_val;
    set_in(s, en_keep, wv, pv);
  endtask

  // Waits for a frame start, then measures high and low lengths in clocks.
  task automatic measure(input int s, input int limit, input int drop_at,
                         input int w1_at, input int w1_val, input int w2_at, input int w2_val,
                         output int hi, output int lo, output int nfs,
                         output bit restarted, output bit ok);
    int   n;
    int   cyc;
    logic en_keep;
    hi = 0; lo = 0; nfs = 0; restarted = 1'b0; ok = 1'b1; n = 0; cyc = 0;
    en_keep = get_en(s);
    while (!(get_pwm(s) && get_fs(s))) begin
      @(negedge clk);
      n++;
      if (n > limit) begin ok = 1'b0; return; end
    end
    while (get_pwm(s)) begin
      if (get_fs(s)) nfs++;
      hi++;
      drive_step(s, cyc, drop_at, w1_at, w1_val, w2_at, w2_val, en_keep);
      @(negedge clk);
      cyc++;
      if (hi > limit) begin ok = 1'b0; return; end
    end
    while (!get_pwm(s) && get_busy(s)) begin
      if (get_fs(s)) nfs++;
      lo++;
      drive_step(s, cyc, drop_at, w1_at, w1_val, w2_at, w2_val, en_keep);
      @(negedge clk);
      cyc++;
      if (lo > limit) begin ok = 1'b0; return; end
    end
    restarted = get_pwm(s);
    set_in(s, en_keep, 1'b0, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   hi, lo, nfs, act, got, expv;
    bit   rs, ok;
    bit   m_busy, m_fs, st, mode, exp_pwm;
    int   m_t, m_act, m_pend;
    logic ren, rwr;
    int   rpos;

    tbl[0] = '{pend: 5,  pos: 0, load_wr: 1'b1, exp_act: 0,  exp_hi: 6,  exp_lo: 36};
    tbl[1] = '{pend: 15, pos: 3, load_wr: 1'b0, exp_act: 15, exp_hi: 36, exp_lo: 6};
    tbl[2] = '{pend: 7,  pos: 9, load_wr: 1'b0, exp_act: 7,  exp_hi: 20, exp_lo: 22};
    tbl[3] = '{pend: 2,  pos: 1, load_wr: 1'b1, exp_act: 1,  exp_hi: 8,  exp_lo: 34};
    tbl[4] = '{pend: 8,  pos: 8, load_wr: 1'b1, exp_act: 8,  exp_hi: 22, exp_lo: 20};

    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 0);
    set_in(1, 1'b0, 1'b0, 0);
    set_in(2, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("reset_pwm",   int'({pwm_a, pwm_b, pwm_c}), 0);
    chk("reset_fs",    int'({fs_a, fs_b, fs_c}), 0);
    chk("reset_busy",  int'({busy_a, busy_b, busy_c}), 0);
    chk("reset_act_a", int'(act_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized run on C against a clock-count reference model
    m_busy = 1'b0; m_t = 0; m_act = 0; m_pend = 0; mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) mode = ~mode;
      ren  = mode ? ($urandom % 16 != 0) : ($urandom % 5 == 0);
      rwr  = ($urandom % 6 == 0);
      rpos = $urandom_range(0, 15);
      set_in(2, ren, rwr, rpos);
      @(posedge clk);
      m_fs = 1'b0;
      st   = 1'b0;
      if (!m_busy) begin
        st = ren;
      end else begin
        m_t++;
        if (m_t == C_FRAME_CLK) begin
          if (ren) st = 1'b1;
          else begin m_busy = 1'b0; m_t = 0; end
        end
      end
      if (st) begin
        m_busy = 1'b1; m_t = 0; m_fs = 1'b1;
        m_act  = rwr ? rpos : m_pend;
      end
      if (rwr) m_pend = rpos;
      exp_pwm = m_busy && (m_t < (C_INIT + m_act) * C_PRE);
      @(negedge clk);
      got  = (int'(pwm_c) << 6) | (int'(fs_c) << 5) | (int'(busy_c) << 4) | int'(act_c);
      expv = (int'(exp_pwm) << 6) | (int'(m_fs) << 5) | (int'(m_busy) << 4) | m_act;
      chk($sformatf("rand_c cycle %0d", i), got, expv);
    end
    set_in(2, 1'b0, 1'b0, 0);
    repeat (100) @(negedge clk);
    chk("c_idle_after_rand", int'(busy_c), 0);

    // Table-driven single frames on C
    foreach (tbl[k]) begin
      set_in(2, 1'b0, 1'b1, tbl[k].pend);
      @(negedge clk);
      set_in(2, 1'b1, tbl[k].load_wr, tbl[k].pos);
      @(negedge clk);
      chk($sformatf("tbl%0d_start_pwm", k), int'(pwm_c), 1);
      chk($sformatf("tbl%0d_act", k), int'(act_c), tbl[k].exp_act);
      measure(2, 200, 0, -1, 0, -1, 0, hi, lo, nfs, rs, ok);
      chk($sformatf("tbl%0d_ok", k), int'(ok), 1);
      chk($sformatf("tbl%0d_high", k), hi, tbl[k].exp_hi);
      chk($sformatf("tbl%0d_low", k), lo, tbl[k].exp_lo);
      chk($sformatf("tbl%0d_nfs", k), nfs, 1);
      chk($sformatf("tbl%0d_restart", k), int'(rs), 0);
    end

    // B: prescale 4, pos 100, single frame
    set_in(1, 1'b0, 1'b1, 100);
    @(negedge clk);
    set_in(1, 1'b1, 1'b0, 0);
    measure(1, 20000, 10, -1, 0, -1, 0, hi, lo, nfs, rs, ok);
    chk("b_ok", int'(ok), 1);
    chk("b_high", hi, 464);
    chk("b_period", hi + lo, 16480);
    chk("b_act", int'(act_b), 100);
    chk("b_nfs", nfs, 1);
    chk("b_restart", int'(rs), 0);

    // A: prescale 1, back-to-back frames with mid-frame writes
    set_in(0, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("a_latency_pwm", int'(pwm_a), 1);
    chk("a_latency_fs", int'(fs_a), 1);
    chk("a_latency_busy", int'(busy_a), 1);
    measure(0, 5000, -1, -1, 0, -1, 0, hi, lo, nfs, rs, ok);
    chk("a_f1_ok", int'(ok), 1);
    chk("a_f1_high", hi, 16);
    chk("a_f1_low", lo, 4104);
    chk("a_f1_nfs", nfs, 1);
    chk("a_f1_restart", int'(rs), 1);
    measure(0, 5000, -1, 5, 4095, -1, 0, hi, lo, nfs, rs, ok);
    chk("a_f2_ok", int'(ok), 1);
    chk("a_f2_high", hi, 16);
    chk("a_f2_low", lo, 4104);
    chk("a_f2_restart", int'(rs), 1);
    chk("a_f3_act", int'(act_a), 4095);
    measure(0, 5000, -1, 100, 10, 200, 2000, hi, lo, nfs, rs, ok);
    chk("a_f3_ok", int'(ok), 1);
    chk("a_f3_high", hi, 4111);
    chk("a_f3_low", lo, 9);
    chk("a_f3_restart", int'(rs), 1);
    chk("a_f4_act", int'(act_a), 2000);
    measure(0, 5000, 50, -1, 0, -1, 0, hi, lo, nfs, rs, ok);
    chk("a_f4_ok", int'(ok), 1);
    chk("a_f4_high", hi, 2016);
    chk("a_f4_low", lo, 2104);
    chk("a_f4_restart", int'(rs), 0);
    act = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_a || fs_a || busy_a) act++;
    end
    chk("a_idle_activity", act, 0);

    // A: reset in the middle of HIGH
    set_in(0, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("a_rst_pre_pwm", int'(pwm_a), 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("a_rst_pwm", int'(pwm_a), 0);
    chk("a_rst_busy", int'(busy_a), 0);
    chk("a_rst_act", int'(act_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(0, 5000, 3, -1, 0, -1, 0, hi, lo, nfs, rs, ok);
    chk("a_post_rst_ok", int'(ok), 1);
    chk("a_post_rst_high", hi, 16);
    chk("a_post_rst_period", hi + lo, 4120);
    chk("a_post_rst_nfs", nfs, 1);
    chk("a_post_rst_act", int'(act_a), 0);
    chk("a_post_rst_restart", int'(rs), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
